// File: rtl/rca_resp_checker.sv
// rca_resp_checker
//
// Output response analyzer for the ripple-carry adder test chain. Every
// applied test vector (a, b, c_in, idx) is sampled together with the adder's
// response {c_out, sum}. The golden sum is recomputed here, per-bit
// mismatches are accumulated, failing patterns are counted, and all
// responses are folded into a MISR signature. After one sweep of
// N_PATTERNS samples the block latches a pass/fail verdict.
//
// Ports
//   clk            system clock, rising edge
//   init           synchronous active-high reset (shared with upstream
//                  pattern counter)
//   a, b, c_in     vector applied to the adder under test
//   idx            current pattern index from the upstream counter
//   sum, c_out     adder-under-test response
//   busy           sweep in progress
//   done           sweep complete, verdict valid
//   fail           any mismatching pattern, or signature mismatch at done
//   err_count      mismatching patterns, saturating at N_PATTERNS
//   fault_map      sticky per-bit mismatch map, {c_out, sum} order
//   first_fail_idx idx of the first mismatching pattern
//   signature      MISR state
//   sig_match      signature equals GOLDEN_SIG (meaningful with done)

module rca_resp_checker #(
  parameter int              WIDTH      = 5,
  parameter int              N_PATTERNS = 8,
  parameter int              IDX_W      = 3,
  parameter logic [WIDTH:0]  GOLDEN_SIG = '0
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W:0]   err_count,
  output logic [WIDTH:0]   fault_map,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [WIDTH:0]   signature,
  output logic             sig_match
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(N_PATTERNS - 1);
  localparam logic [IDX_W:0] MAX_ERR  = (IDX_W+1)'(N_PATTERNS);

  // Error counter increment that pins at N_PATTERNS instead of wrapping.
  function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] cnt);
    if (cnt >= MAX_ERR) begin
      return MAX_ERR;
    end
    return cnt + 1'b1;
  endfunction

  // One MISR step, polynomial x^6 + x + 1 for the default width:
  // feedback from the MSB enters bits 0 and 1, every other bit shifts up.
  function automatic logic [WIDTH:0] misr_next(input logic [WIDTH:0] sig,
                                               input logic [WIDTH:0] obs);
    logic             fb;
    logic [WIDTH:0]   nxt;
    fb     = sig[WIDTH];
    nxt    = '0;
    nxt[0] = fb ^ obs[0];
    nxt[1] = sig[0] ^ fb ^ obs[1];
    for (int i = 2; i <= WIDTH; i++) begin
      nxt[i] = sig[i-1] ^ obs[i];
    end
    return nxt;
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W:0]   cnt_p1;
  logic [IDX_W:0]   err_p1;
  logic [WIDTH:0]   map_p1;
  logic [IDX_W-1:0] ffi_p1;
  logic [WIDTH:0]   sig_p1;

  logic [WIDTH:0]   exp_p0;
  logic [WIDTH:0]   obs_p0;
  logic [WIDTH:0]   diff_p0;
  logic             mis_p0;
  logic             vld_p0;

  // ---- stage p0: golden compare on the live bus ----
  // Operands are zero-extended so the carry out lands in bit WIDTH.
  assign exp_p0  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
  assign obs_p0  = {c_out, sum};
  assign diff_p0 = exp_p0 ^ obs_p0;
  assign mis_p0  = |diff_p0;
  // Only RUN cycles carry a sample; the IDLE->RUN edge is a warm-up edge.
  assign vld_p0  = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (cnt_p1 == LAST_CNT) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p1: accumulated results ----
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_p1  <= '0;
      err_p1  <= '0;
      map_p1  <= '0;
      ffi_p1  <= '0;
      sig_p1  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      if (vld_p0) begin
        cnt_p1 <= cnt_p1 + 1'b1;
        map_p1 <= map_p1 | diff_p0;
        sig_p1 <= misr_next(sig_p1, obs_p0);
        if (mis_p0) begin
          err_p1 <= sat_inc(err_p1);
          // Capture idx only for the very first failing pattern.
          if (err_p1 == '0) begin
            ffi_p1 <= idx;
          end
        end
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_p1;
  assign fault_map      = map_p1;
  assign first_fail_idx = ffi_p1;
  assign signature      = sig_p1;
  assign sig_match      = (sig_p1 == GOLDEN_SIG);
  // The signature only counts against the adder once the sweep is complete.
  assign fail           = (err_p1 != '0) | (done_q & ~sig_match);

endmodule
